apb_master_ctrl: RTL

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_ctrl_pkg.sv | 26 ++
 rtl/apb_master_ctrl_if.sv | 43 ++++
 rtl/apb_master_ctrl_decoder.sv | 31 +++
 rtl/apb_master_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and constants for the APB master controller and its address decoder.
// Latency: none (declarations only).
// Backpressure: n/a.
package apb_ctrl_pkg;

  // Controller phases: IDLE accepts requests, SETUP/ACCESS run an APB transfer,
  // ERR reports a request to an address no slave owns.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } apb_state_e;

  // Slave regions, matched against address bits [31:26].
  localparam logic [5:0] REGION_S0 = 6'h20;
  localparam logic [5:0] REGION_S1 = 6'h21;
  localparam logic [5:0] REGION_S2 = 6'h22;

  // One-hot PSEL per slave; all-zero means no slave is selected.
  localparam logic [2:0] PSEL_NONE = 3'b000;
  localparam logic [2:0] PSEL_S0   = 3'b001;
  localparam logic [2:0] PSEL_S1   = 3'b010;
  localparam logic [2:0] PSEL_S2   = 3'b100;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB bus of the controller, bundled as one interface.
// Latency: none (wires only).
// Backpressure: req_ready gates request acceptance; the APB side stalls on pready.
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 32
);

  // Request side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  // Completion side
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  // APB bus
  logic [2:0]        pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;

  // Controller view
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, resp_valid, resp_err, resp_rdata,
           pselx, penable, pwrite, paddr, pwdata
  );

  // Requester/slave view (used by whatever drives the controller)
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           pselx, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_ctrl_decoder.sv
// Maps address bits [31:26] onto a one-hot slave select and a mapped flag.
// Latency: combinational.
// Backpressure: none.
module apb_addr_decoder
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [2:0]        pselx_o,
  output logic              mapped_o
);

  // Only the region field selects a slave; the remaining bits are offsets
  // inside the slave and are intentionally ignored here.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  // Region lookup; anything outside the three slave regions is unmapped.
  always_comb begin
    pselx_o = PSEL_NONE;
    case (addr_i[31:26])
      REGION_S0: pselx_o = PSEL_S0;
      REGION_S1: pselx_o = PSEL_S1;
      REGION_S2: pselx_o = PSEL_S2;
      default:   pselx_o = PSEL_NONE;
    endcase
    mapped_o = (pselx_o != PSEL_NONE);
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: takes one request, runs SETUP/ACCESS, returns a completion pulse.
// Latency: accept at N, SETUP N+1, ACCESS N+2, response >= N+3 (unmapped: response at N+2).
// Backpressure: req_ready only in IDLE; ACCESS waits on pready up to TIMEOUT cycles, then errors.
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic               hclk,
  input  logic               hresetn,
  apb_master_ctrl_if.master  bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  // Last wait count from which one more stalled cycle reaches TIMEOUT.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e        state_q;
  logic [2:0]        pselx_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;

  logic [2:0]        dec_pselx;
  logic              dec_mapped;

  apb_addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_addr_decoder (
    .addr_i   (bus.req_addr),
    .pselx_o  (dec_pselx),
    .mapped_o (dec_mapped)
  );

  // Saturating wait-cycle increment so the counter can never wrap.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Transfer sequencer: every bus and response output is registered here.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= ST_IDLE;
      pselx_q      <= PSEL_NONE;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      // Response is a one-cycle pulse; the error flag only rides along with it.
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwdata_q <= bus.req_wdata;
            pwrite_q <= bus.req_write;
            if (dec_mapped) begin
              pselx_q   <= dec_pselx;
              penable_q <= 1'b0;
              state_q   <= ST_SETUP;
            end else begin
              state_q   <= ST_ERR;
            end
          end
        end

        ST_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (bus.pready) begin
            // A ready on the timeout edge still completes normally.
            resp_valid_q <= 1'b1;
            pselx_q      <= PSEL_NONE;
            penable_q    <= 1'b0;
            state_q      <= ST_IDLE;
            if (!pwrite_q) begin
              resp_rdata_q <= bus.prdata;
            end
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_q == CNT_LAST) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              pselx_q      <= PSEL_NONE;
              penable_q    <= 1'b0;
              state_q      <= ST_IDLE;
            end
          end
        end

        ST_ERR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          state_q      <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.pselx      = pselx_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
